// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus for bin2bcd_seq.
// Define BIN2BCD_LZB_EN to add the per-digit leading-zero blank flags.
interface bin2bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_LZB_EN
   logic [DIGITS-1:0]     blank;
`endif

   modport master (
      output start,
      output bin,
      input  busy,
      input  done,
`ifdef BIN2BCD_LZB_EN
      input  blank,
`endif
      input  bcd
   );

   modport slave (
      input  start,
      input  bin,
      output busy,
      output done,
`ifdef BIN2BCD_LZB_EN
      output blank,
`endif
      output bcd
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_LZB_EN to register leading-zero blank flags alongside bcd.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | add-3 then shift, WIDTH iterations
// S_DONE  | result cycle: done=1, bcd updated, may accept a new start
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic          clk,
   input  logic          rst,
   bin2bcd_seq_if.slave  bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   function automatic bit digits_ok();
      longint p;
      p = 1;
      for (int k = 0; k < DIGITS; k++) p = p * 10;
      return p > ((longint'(1) << WIDTH) - 1);
   endfunction

   generate
      if (!digits_ok()) begin : g_bad_digits
         $fatal(1, "bin2bcd_seq: DIGITS too small to hold 2^WIDTH-1");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_shift;
   logic [BW-1:0]     r_acc;
   logic [CW-1:0]     r_cnt;
   logic              r_busy;
   logic              r_done;
   logic [BW-1:0]     r_bcd;

   logic [BW-1:0]     w_adj;
   logic [BW-1:0]     w_acc_nxt;

   always_comb begin
      w_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? r_acc[4*i +: 4] + 4'd3
                                                      : r_acc[4*i +: 4];
      end
   end

   assign w_acc_nxt = {w_adj[BW-2:0], r_shift[WIDTH-1]};

`ifdef BIN2BCD_LZB_EN
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
   logic [DIGITS-1:0] r_blank;
   logic [DIGITS-1:0] w_blank_nxt;

   // A digit blanks only if it and every digit above it is zero.
   always_comb begin
      logic v_zero;
      v_zero      = 1'b1;
      w_blank_nxt = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         v_zero         = v_zero & (w_acc_nxt[4*i +: 4] == 4'd0);
         w_blank_nxt[i] = v_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_blank <= BLANK_RST;
      else if (r_state == S_SHIFT && r_cnt == CW'(1))
         r_blank <= w_blank_nxt;
   end

   assign bus.blank = r_blank;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_bcd   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_shift <= bus.bin;
                  r_acc   <= '0;
                  r_cnt   <= CW'(WIDTH);
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               r_acc   <= w_acc_nxt;
               r_shift <= r_shift << 1;
               r_cnt   <= r_cnt - CW'(1);
               // Final iteration publishes the result directly so done and bcd align.
               if (r_cnt == CW'(1)) begin
                  r_bcd   <= w_acc_nxt;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.bcd  = r_bcd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus queues expected results, a monitor checks them.
// Blank flags are checked when BIN2BCD_LZB_EN is defined.
module tb_bin2bcd_seq;
   localparam int W = 8;
   localparam int D = 3;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_fail;

   bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus_if ();

   bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic [4*D-1:0] bcd;
      logic [D-1:0]   blank;
      int             acc;
      int             due;
   } exp_t;

   exp_t q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Decimal reference: digits from plain division, blanks from magnitude.
   function automatic logic [4*D-1:0] ref_bcd(input int v);
      logic [4*D-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [D-1:0] ref_blank(input int v);
      logic [D-1:0] b;
      int p;
      b = '0;
      p = 10;
      for (int i = 1; i < D; i++) begin
         b[i] = (v < p);
         p = p * 10;
      end
      return b;
   endfunction

   task automatic push(input int v);
      exp_t e;
      e.bcd   = ref_bcd(v);
      e.blank = ref_blank(v);
      e.acc   = cyc;
      e.due   = cyc + W;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input int v);
      bus_if.start = 1'b1;
      bus_if.bin   = W'(v);
      tick();
      bus_if.start = 1'b0;
      push(v);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 4 * W && q.size() != 0; k++) tick();
      if (q.size() != 0) begin
         chk("wait_idle_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus_if.done), 32'd0);
      chk({tag, "_bcd"},  32'(bus_if.bcd),  32'd0);
`ifdef BIN2BCD_LZB_EN
      chk({tag, "_blank"}, 32'(bus_if.blank), 32'b110);
`endif
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic exp_busy;
      if (!rst) begin
         exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].due);
         chk("busy", 32'(bus_if.busy), 32'(exp_busy));
         if (bus_if.busy && bus_if.done) chk("busy_and_done", 32'd1, 32'd0);
         if (bus_if.done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.due));
               chk("bcd", 32'(bus_if.bcd), 32'(e.bcd));
`ifdef BIN2BCD_LZB_EN
               chk("blank", 32'(bus_if.blank), 32'(e.blank));
`endif
            end
         end else if (q.size() > 0 && cyc >= q[0].due) begin
            chk("missing_done", 32'd0, 32'd1);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      int v;
      n_chk  = 0;
      n_fail = 0;
      rst          = 1'b1;
      bus_if.start = 1'b0;
      bus_if.bin   = '0;
      repeat (3) tick();
      chk_reset_state("por");
      rst = 1'b0;
      tick();

      go(255); wait_idle();
      go(0);   wait_idle();
      go(100); wait_idle();
      go(9);   wait_idle();
      go(7);   wait_idle();
      go(40);  wait_idle();

      // Start during busy must be ignored.
      go(200);
      repeat (2) tick();
      bus_if.start = 1'b1;
      bus_if.bin   = 8'd17;
      tick();
      bus_if.start = 1'b0;
      wait_idle();
      repeat (12) tick();

      // Reset mid-conversion discards the partial result.
      go(123);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      q.delete();
      chk_reset_state("mid_rst");
      rst = 1'b0;
      tick();
      repeat (12) tick();
      go(45); wait_idle();

      // Back-to-back: new start in the done cycle.
      go(250);
      repeat (W) tick();
      go(7);
      wait_idle();
      repeat (3) tick();

      // Back-to-back exhaustive sweep.
      bus_if.start = 1'b1;
      for (int s = 0; s < 256; s++) begin
         bus_if.bin = W'(s);
         tick();
         push(s);
         if (s == 255) bus_if.start = 1'b0;
         repeat (W) tick();
      end
      wait_idle();

      // Random values, random gaps, random ignored starts while busy.
      for (int n = 0; n < 120; n++) begin
         v = int'($urandom_range(0, 255));
         go(v);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 5)) tick();
            bus_if.start = 1'b1;
            bus_if.bin   = W'($urandom);
            tick();
            bus_if.start = 1'b0;
         end
         wait_idle();
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (15) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
